// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Entry 0 reads as zero and is never busy. Writes resolve by fixed priority,
// with the highest-index port winning. Same-cycle write-to-read forwarding is optional.
module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned N      = 5,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*N-1:0]    wa_i,
  input  logic [NWR*XLEN-1:0] wd_i,
  input  logic [NRD*N-1:0]    ra_i,
  output logic [NRD*XLEN-1:0] rd_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                rsv_en_i,
  input  logic [N-1:0]        rsv_addr_i,
  output logic [N:0]          busy_cnt_o
);

  localparam int unsigned Depth = 2 ** N;

  // Entry 0 is never written, so its flops are constant zero and drop out in synthesis.
  logic [XLEN-1:0]  mem_q   [Depth];
  logic [XLEN-1:0]  mem_d   [Depth];
  logic [XLEN-1:0]  wr_data [Depth];
  logic [Depth-1:0] wr_hit;
  logic [Depth-1:0] rsv_hit;
  logic [Depth-1:0] busy_q, busy_d;
  logic [N:0]       cnt_q, cnt_d;
  logic [N-1:0]     raddr;

  // Per-entry write decode; later ports override earlier ones.
  always_comb begin
    for (int unsigned a = 0; a < Depth; a++) begin
      wr_hit[a]  = 1'b0;
      wr_data[a] = '0;
      rsv_hit[a] = rsv_en_i && (rsv_addr_i == N'(a)) && (a != 0);
      for (int unsigned k = 0; k < NWR; k++) begin
        if ((a != 0) && we_i[k] && (wa_i[k*N +: N] == N'(a))) begin
          wr_hit[a]  = 1'b1;
          wr_data[a] = wd_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Next-state storage, busy bits and their population count.
  always_comb begin
    cnt_d = '0;
    for (int unsigned a = 0; a < Depth; a++) begin
      mem_d[a] = wr_hit[a] ? wr_data[a] : mem_q[a];
      // A fresh reservation outranks a retiring write to the same register.
      if (rsv_hit[a]) begin
        busy_d[a] = 1'b1;
      end else if (wr_hit[a]) begin
        busy_d[a] = 1'b0;
      end else begin
        busy_d[a] = busy_q[a];
      end
      cnt_d = cnt_d + (N+1)'(busy_d[a]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < Depth; a++) begin
        mem_q[a] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports with optional forwarding of the winning write.
  always_comb begin
    rd_o      = '0;
    rd_busy_o = '0;
    raddr     = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      raddr = ra_i[i*N +: N];
      if (raddr != '0) begin
        if (BYPASS && wr_hit[raddr]) begin
          rd_o[i*XLEN +: XLEN] = wr_data[raddr];
        end else begin
          rd_o[i*XLEN +: XLEN] = mem_q[raddr];
        end
        rd_busy_o[i] = busy_q[raddr] && !(BYPASS && wr_hit[raddr]);
      end
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a forwarding and a non-forwarding
// instance share stimulus; a small 4-entry, 3-write-port instance covers a full scoreboard.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32, N = 5, NRD = 2, NWR = 2;
  localparam int unsigned CX = 8, CN = 2, CNRD = 1, CNWR = 3;

  localparam int unsigned KRdA = 0, KBusyA = 1, KCntA = 2;
  localparam int unsigned KRdB = 3, KBusyB = 4, KCntB = 5;
  localparam int unsigned KRdC = 6, KBusyC = 7, KCntC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NWR-1:0]      we;
  logic [NWR*N-1:0]    wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*N-1:0]    ra;
  logic                rsv_en;
  logic [N-1:0]        rsv_addr;
  logic [NRD*XLEN-1:0] rd_a, rd_b;
  logic [NRD-1:0]      rdb_a, rdb_b;
  logic [N:0]          cnt_a, cnt_b;

  logic [CNWR-1:0]      we_c;
  logic [CNWR*CN-1:0]   wa_c;
  logic [CNWR*CX-1:0]   wd_c;
  logic [CNRD*CN-1:0]   ra_c;
  logic                 rsv_en_c;
  logic [CN-1:0]        rsv_addr_c;
  logic [CNRD*CX-1:0]   rd_c;
  logic [CNRD-1:0]      rdb_c;
  logic [CN:0]          cnt_c;

  regfile_mp #(.XLEN(XLEN), .N(N), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra), .rd_o(rd_a),
    .rd_busy_o(rdb_a), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_cnt_o(cnt_a)
  );

  regfile_mp #(.XLEN(XLEN), .N(N), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra), .rd_o(rd_b),
    .rd_busy_o(rdb_b), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_cnt_o(cnt_b)
  );

  regfile_mp #(.XLEN(CX), .N(CN), .NRD(CNRD), .NWR(CNWR), .BYPASS(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .we_i(we_c), .wa_i(wa_c), .wd_i(wd_c), .ra_i(ra_c), .rd_o(rd_c),
    .rd_busy_o(rdb_c), .rsv_en_i(rsv_en_c), .rsv_addr_i(rsv_addr_c), .busy_cnt_o(cnt_c)
  );

  typedef struct {
    string       name;
    int unsigned kind;
    int unsigned port;
    logic [31:0] val;
    logic [31:0] act;
    bit          got;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic logic [31:0] observe(int unsigned kind, int unsigned port);
    case (kind)
      KRdA:    return rd_a[port*XLEN +: XLEN];
      KBusyA:  return {31'b0, rdb_a[port]};
      KCntA:   return 32'(cnt_a);
      KRdB:    return rd_b[port*XLEN +: XLEN];
      KBusyB:  return {31'b0, rdb_b[port]};
      KCntB:   return 32'(cnt_b);
      KRdC:    return 32'(rd_c);
      KBusyC:  return {31'b0, rdb_c[0]};
      KCntC:   return 32'(cnt_c);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic exp_push(string name, int unsigned kind, int unsigned port, logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.port = port; e.val = val; e.act = '0; e.got = 1'b0;
    sb.push_back(e);
  endtask

  // Latch DUT outputs into every not-yet-sampled scoreboard entry.
  task automatic sample();
    #1;
    foreach (sb[j]) begin
      if (!sb[j].got) begin
        sb[j].act = observe(sb[j].kind, sb[j].port);
        sb[j].got = 1'b1;
      end
    end
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0;
    we_c = '0; wa_c = '0; wd_c = '0; rsv_en_c = 1'b0; rsv_addr_c = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int unsigned k, logic [N-1:0] a, logic [XLEN-1:0] d);
    we[k] = 1'b1;
    wa[k*N +: N] = a;
    wd[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_ra(int unsigned i, logic [N-1:0] a);
    ra[i*N +: N] = a;
  endtask

  task automatic push_both(string name, int unsigned ka, int unsigned port, logic [31:0] v);
    exp_push({name, "_a"}, ka, port, v);
    exp_push({name, "_b"}, ka + 3, port, v);
  endtask

  task automatic test_reset();
    exp_t e;
    #2;
    set_ra(0, 5'd1); set_ra(1, 5'd7);
    push_both("rst_rd0", KRdA, 0, 0);
    push_both("rst_rd1", KRdA, 1, 0);
    push_both("rst_busy0", KBusyA, 0, 0);
    push_both("rst_cnt", KCntA, 0, 0);
    exp_push("rst_cnt_c", KCntC, 0, 0);
    sample();
    // Requests presented on an edge while reset is held must be lost.
    wr(0, 5'd1, 32'hCAFE_0001); rsv_en = 1'b1; rsv_addr = 5'd1;
    step();
    idle();
    push_both("rst_edge_rd", KRdA, 0, 0);
    push_both("rst_edge_cnt", KCntA, 0, 0);
    sample();
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (e.act !== e.val) begin
        errors++; $display("FAIL %s: got 0x%h expected 0x%h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_reset_mid_and_zero();
    exp_t e;
    step();
    wr(0, 5'd1, 32'h1111_0001); wr(1, 5'd2, 32'h2222_0002);
    rsv_en = 1'b1; rsv_addr = 5'd6;
    step();
    idle();
    set_ra(0, 5'd1); set_ra(1, 5'd2);
    push_both("fill_rd0", KRdA, 0, 32'h1111_0001);
    push_both("fill_rd1", KRdA, 1, 32'h2222_0002);
    push_both("fill_cnt", KCntA, 0, 1);
    sample();
    @(negedge clk);
    #2 rst_n = 1'b0;
    push_both("mid_rst_rd0", KRdA, 0, 0);
    push_both("mid_rst_rd1", KRdA, 1, 0);
    push_both("mid_rst_cnt", KCntA, 0, 0);
    sample();
    wr(0, 5'd1, 32'hDEAD_0001); rsv_en = 1'b1; rsv_addr = 5'd6;
    step();
    idle();
    push_both("mid_rst_edge_rd0", KRdA, 0, 0);
    push_both("mid_rst_edge_cnt", KCntA, 0, 0);
    sample();
    rst_n = 1'b1;
    step();
    wr(0, 5'd0, 32'hDEAD_BEEF); rsv_en = 1'b1; rsv_addr = 5'd0;
    set_ra(0, 5'd0); set_ra(1, 5'd0);
    push_both("zero_same_rd", KRdA, 0, 0);
    push_both("zero_same_busy", KBusyA, 0, 0);
    sample();
    step();
    idle();
    push_both("zero_next_rd", KRdA, 1, 0);
    push_both("zero_next_busy", KBusyA, 1, 0);
    push_both("zero_next_cnt", KCntA, 0, 0);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (e.act !== e.val) begin
        errors++; $display("FAIL %s: got 0x%h expected 0x%h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_priority_and_bypass();
    exp_t e;
    step();
    wr(0, 5'd5, 32'h1111_1111); wr(1, 5'd5, 32'h2222_2222);
    set_ra(0, 5'd5);
    exp_push("prio_same_a", KRdA, 0, 32'h2222_2222);
    exp_push("prio_same_b", KRdB, 0, 32'h0);
    sample();
    step();
    idle();
    push_both("prio_next", KRdA, 0, 32'h2222_2222);
    sample();
    wr(0, 5'd7, 32'hA5A5_A5A5);
    set_ra(1, 5'd7);
    exp_push("byp_same_a", KRdA, 1, 32'hA5A5_A5A5);
    exp_push("byp_same_b", KRdB, 1, 32'h0);
    sample();
    step();
    idle();
    push_both("byp_next", KRdA, 1, 32'hA5A5_A5A5);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (e.act !== e.val) begin
        errors++; $display("FAIL %s: got 0x%h expected 0x%h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_scoreboard_and_collision();
    exp_t e;
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3; set_ra(0, 5'd3);
    push_both("sb_pre_busy", KBusyA, 0, 0);
    sample();
    step();
    rsv_addr = 5'd4;
    push_both("sb_busy3", KBusyA, 0, 1);
    push_both("sb_cnt1", KCntA, 0, 1);
    sample();
    step();
    rsv_addr = 5'd3;
    push_both("sb_cnt2", KCntA, 0, 2);
    sample();
    step();
    idle();
    push_both("sb_cnt2_again", KCntA, 0, 2);
    sample();
    wr(0, 5'd3, 32'h0000_0033);
    exp_push("sb_wr_busy_a", KBusyA, 0, 0);
    exp_push("sb_wr_busy_b", KBusyB, 0, 1);
    sample();
    step();
    idle();
    push_both("sb_wr_busy_next", KBusyA, 0, 0);
    push_both("sb_wr_cnt", KCntA, 0, 1);
    push_both("sb_wr_rd", KRdA, 0, 32'h0000_0033);
    sample();
    rsv_en = 1'b1; rsv_addr = 5'd9; set_ra(1, 5'd9);
    step();
    idle();
    push_both("col_pre_busy", KBusyA, 1, 1);
    push_both("col_pre_cnt", KCntA, 0, 2);
    sample();
    rsv_en = 1'b1; rsv_addr = 5'd9; wr(1, 5'd9, 32'h5);
    exp_push("col_same_rd_a", KRdA, 1, 32'h5);
    exp_push("col_same_rd_b", KRdB, 1, 32'h0);
    sample();
    step();
    idle();
    push_both("col_busy", KBusyA, 1, 1);
    push_both("col_cnt", KCntA, 0, 2);
    push_both("col_rd", KRdA, 1, 32'h5);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (e.act !== e.val) begin
        errors++; $display("FAIL %s: got 0x%h expected 0x%h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_full_scoreboard();
    exp_t e;
    step();
    rsv_en_c = 1'b1; rsv_addr_c = 2'd1;
    step();
    rsv_addr_c = 2'd2;
    exp_push("full_cnt1", KCntC, 0, 1);
    sample();
    step();
    rsv_addr_c = 2'd3;
    step();
    idle();
    ra_c = 2'd2;
    exp_push("full_cnt3", KCntC, 0, 3);
    exp_push("full_busy2", KBusyC, 0, 1);
    sample();
    rsv_en_c = 1'b1; rsv_addr_c = 2'd0;
    step();
    idle();
    exp_push("full_rsv0_cnt", KCntC, 0, 3);
    sample();
    we_c = 3'b111; wa_c = {2'd3, 2'd2, 2'd1}; wd_c = {8'h33, 8'h22, 8'h11};
    exp_push("full_wr_byp", KRdC, 0, 32'h22);
    exp_push("full_wr_busy_byp", KBusyC, 0, 0);
    sample();
    step();
    idle();
    exp_push("full_clear_cnt", KCntC, 0, 0);
    exp_push("full_rd2", KRdC, 0, 32'h22);
    sample();
    ra_c = 2'd3;
    exp_push("full_rd3", KRdC, 0, 32'h33);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (e.act !== e.val) begin
        errors++; $display("FAIL %s: got 0x%h expected 0x%h", e.name, e.act, e.val);
      end
    end
  endtask

  // Constrained-random traffic on a few low registers against a behavioural model.
  task automatic test_random();
    exp_t            e;
    logic [XLEN-1:0] mem_m  [32];
    bit              busy_m [32];
    int unsigned     a, wa_k, pop;
    bit              hit;
    logic [XLEN-1:0] bd;
    step();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int j = 0; j < 32; j++) begin
      mem_m[j] = '0; busy_m[j] = 1'b0;
    end
    for (int c = 0; c < 60; c++) begin
      step();
      for (int k = 0; k < NWR; k++) begin
        we[k] = 1'($urandom_range(0, 1));
        wa[k*N +: N] = 5'($urandom_range(0, 7));
        wd[k*XLEN +: XLEN] = $urandom;
      end
      rsv_en = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) set_ra(i, 5'($urandom_range(0, 7)));
      for (int i = 0; i < NRD; i++) begin
        a = 32'(ra[i*N +: N]);
        hit = 1'b0; bd = '0;
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && 32'(wa[k*N +: N]) == a) begin
            hit = 1'b1; bd = wd[k*XLEN +: XLEN];
          end
        end
        exp_push("rnd_rd_a", KRdA, i, (a == 0) ? '0 : (hit ? bd : mem_m[a]));
        exp_push("rnd_rd_b", KRdB, i, (a == 0) ? '0 : mem_m[a]);
        exp_push("rnd_busy_a", KBusyA, i, {31'b0, (a != 0) && busy_m[a] && !hit});
        exp_push("rnd_busy_b", KBusyB, i, {31'b0, (a != 0) && busy_m[a]});
      end
      pop = 0;
      for (int j = 1; j < 32; j++) pop += int'(busy_m[j]);
      push_both("rnd_cnt", KCntA, 0, pop);
      sample();
      for (int k = 0; k < NWR; k++) begin
        wa_k = 32'(wa[k*N +: N]);
        if (we[k] && wa_k != 0) begin
          mem_m[wa_k] = wd[k*XLEN +: XLEN];
          busy_m[wa_k] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) busy_m[rsv_addr] = 1'b1;
    end
    step();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (e.act !== e.val) begin
        errors++; $display("FAIL %s port %0d: got 0x%h expected 0x%h", e.name, e.port, e.act,
                           e.val);
      end
    end
  endtask

  initial begin
    idle();
    ra = '0;
    ra_c = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_reset_mid_and_zero();
    test_priority_and_bypass();
    test_scoreboard_and_collision();
    test_full_scoreboard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with scoreboard for the pipelined core: 2**N entries of XLEN bits, NRD combinational read ports, NWR clocked write ports with fixed priority, optional write-to-read bypass, and per-register busy bits for RAW hazard tracking. It sits between decode (reads, reservations) and writeback (writes, busy clear). Entry 0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits (>= 1)
- N, 5, address width; depth = 2**N (N >= 1)
- NRD, 2, number of read ports (>= 1)
- NWR, 2, number of write ports (>= 1)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-edge contents
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  NWR  write enable per write port
- wa  in  NWR*N  write addresses; port k at bits [k*N +: N]
- wd  in  NWR*XLEN  write data; port k at bits [k*XLEN +: XLEN]
- ra  in  NRD*N  read addresses; port i at bits [i*N +: N]
- rd  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  busy flag of the register addressed by read port i
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  N  register to reserve
- busy_cnt  out  N+1  number of registers currently busy

One clock; reset is asynchronous and active-low.

## Operation
- Storage: entries 1..2**N-1 are flops; entry 0 is not stored, always reads 0, is never busy.
- Write: at posedge, for each entry a != 0, if any port k has we[k] and wa[k]==a, the entry takes wd of the highest-index such port. Writes to 0 are dropped.
- Read (combinational): rd[i] = 0 if ra[i]==0; else if BYPASS and a write hits ra[i] this cycle, the winning port's wd; else stored value.
- Busy bits, one per entry 1..2**N-1, at posedge:
  - set if rsv_en and rsv_addr==a
  - else cleared if any we[k] with wa[k]==a
  - else hold
  - Reserve wins over same-cycle write to the same address: a new producer has issued; the write data is still stored.
  - rsv_addr==0 is ignored.
- rd_busy[i] = busy[ra[i]], forced 0 when ra[i]==0, and (BYPASS only) forced 0 when a write hits ra[i] this cycle.
- busy_cnt: registered population count of busy bits, kept consistent with the bits every cycle (equivalently next = current + sets - clears). Never exceeds 2**N-1.
- Writes to a non-busy register are legal: data stored, busy unchanged.

## Timing
- Reset (rst_n low, asynchronous): all entries 0, all busy bits 0, busy_cnt 0. Outputs are combinational from state, so rd = 0 and rd_busy = 0 during reset.
- Release: first rising edge with rst_n high performs normal updates.
- Reset asserted mid-operation clears state immediately regardless of clk. Writes and reservations on the edge where rst_n is low are lost.
- Write latency: 1 edge to storage. With BYPASS=1, data is visible on rd in the same cycle; with BYPASS=0, visible the cycle after the edge.
- Reserve latency: rd_busy and busy_cnt reflect the reservation the cycle after the edge.
- Read ports are fully independent; any number may address the same entry.
- No handshake: all requests are accepted every cycle.

## Test plan
- Reset/zero: assert rst_n=0 mid-run after filling entries. Then write wd=0xDEADBEEF to addr 0 and read ra=0 -> rd=0 throughout, busy_cnt=0, rd_busy=0.
- Priority: same edge we=2'b11, wa0=wa1=5, wd0=0x11111111, wd1=0x22222222 -> next cycle rd(ra=5)=0x22222222. With BYPASS=1, the same cycle also shows 0x22222222.
- Bypass modes: write 0xA5A5A5A5 to reg 7 holding 0x0, read ra=7 in the same cycle -> BYPASS=1 gives 0xA5A5A5A5; BYPASS=0 gives 0x0, then 0xA5A5A5A5 next cycle.
- Scoreboard: reserve 3, 4, 3 on successive edges -> busy_cnt 1, 2, 2. Write reg 3 -> rd_busy(ra=3)=0 (same cycle when BYPASS=1, otherwise next), busy_cnt=1.
- Collision: reg 9 busy; same edge rsv_en with rsv_addr=9 and we with wa=9, wd=0x5 -> reg 9 stays busy, busy_cnt unchanged, rd(ra=9)=0x5.
- Full scoreboard: N=2, reserve 1, 2, 3 -> busy_cnt=3. Reserving 0 -> no change. Writes to 1, 2, 3 on one edge (NWR=3) -> busy_cnt=0.
